// File: rtl/kbd_pkg.sv
// Shared types for the keyboard operation queue: op-code width and type,
// plus the upstream handshake FSM states.
package kbd_pkg;

    localparam int DATA_WIDTH = 3;

    typedef logic [DATA_WIDTH-1:0] kbd_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } kbd_up_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/kbd_op_queue.sv
// Circular FIFO of key operations between the decoder handshake and game logic.
// Define KBD_QUEUE_OVERWRITE_EN to overwrite the oldest entry when full.
module kbd_op_queue
    import kbd_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int DATA_WIDTH     = 3,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_read_fin,
    output logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_read_fin,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DROP_CNT_WIDTH-1:0]    drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic                  in_ready_s;
    kbd_up_state_e         state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  rd_fin_q, rd_fin_d;
    logic                  push_ok, capture, pop, drop, push_eff;

    sync_2ff #(.WIDTH(1)) u_in_ready_sync (
        .clk   (clock),
        .rst_n (reset_n),
        .d     (in_ready),
        .q     (in_ready_s)
    );

`ifdef KBD_QUEUE_OVERWRITE_EN
    logic                      full;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign push_ok = 1'b1;
`else
    assign push_ok = (count_q < CNT_W'(DEPTH));
`endif

    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        rd_fin_d = out_read_fin;

        // The FSM acks a capture even in a flush cycle; only the storage discards it.
        capture = (state_q == IDLE) && in_ready_s && push_ok;
        pop     = out_read_fin && !rd_fin_q && (count_q != '0);
`ifdef KBD_QUEUE_OVERWRITE_EN
        drop    = capture && full && !pop && !flush;
`else
        drop    = 1'b0;
`endif
        push_eff = capture && !drop;

        unique case (state_q)
            IDLE: if (capture)     state_d = ACK;
            ACK:  if (!in_ready_s) state_d = IDLE;
            default:               state_d = IDLE;
        endcase

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (capture) begin
                mem_d[tail_q] = in_data;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (pop || drop) head_d = head_q + PTR_W'(1);
            if (push_eff && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push_eff) count_d = count_q - CNT_W'(1);
        end
    end

`ifdef KBD_QUEUE_OVERWRITE_EN
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mem_q    <= '{default: '0};
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rd_fin_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rd_fin_q <= rd_fin_d;
        end
    end

    assign in_read_fin = (state_q == ACK);
    assign out_ready   = (count_q != '0);
    assign out_data    = mem_q[head_q];
    assign count       = count_q;

endmodule

// File: tb/tb_kbd_op_queue.sv
// Randomized bench for kbd_op_queue against a queue-based reference model.
module tb_kbd_op_queue;

    localparam int DEPTH = 8;
    localparam int DW    = 3;
    localparam int DCW   = 8;
    localparam int BUDGET = 20;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           in_ready = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_read_fin;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic           out_read_fin = 1'b0;
    logic           flush = 1'b0;
    logic [3:0]     count;
    logic [DCW-1:0] drop_cnt;

    int n_vec = 0;
    int n_err = 0;
    int model[$];
    int drops = 0;

    kbd_op_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .DROP_CNT_WIDTH(DCW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_read_fin  (in_read_fin),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_read_fin (out_read_fin),
        .flush        (flush),
        .count        (count),
        .drop_cnt     (drop_cnt)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".count"}, 32'(count), 32'(model.size()));
        check({tag, ".out_ready"}, 32'(out_ready), 32'(model.size() != 0));
        if (model.size() != 0) check({tag, ".out_data"}, 32'(out_data), 32'(model[0]));
        check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(drops));
    endtask

    function automatic void model_push(input int d);
`ifdef KBD_QUEUE_OVERWRITE_EN
        if (model.size() == DEPTH) begin
            void'(model.pop_front());
            if (drops < 255) drops++;
        end
`endif
        model.push_back(d % (1 << DW));
    endfunction

    task automatic wait_fin(input logic level, input string tag);
        int waited = 0;
        while (in_read_fin !== level && waited < BUDGET) begin
            step();
            waited++;
        end
        check(tag, 32'(in_read_fin), 32'(level));
    endtask

    task automatic push_op(input int d);
        in_data  = DW'(d);
        in_ready = 1'b1;
        wait_fin(1'b1, "push.ack");
        model_push(d);
        check_model("push");
        in_ready = 1'b0;
        wait_fin(1'b0, "push.release");
    endtask

    task automatic pop_op();
        out_read_fin = 1'b1;
        step();
        out_read_fin = 1'b0;
        if (model.size() != 0) void'(model.pop_front());
        check_model("pop");
        step();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        check("rst.in_read_fin", 32'(in_read_fin), 0);
        check("rst.out_ready", 32'(out_ready), 0);
        check("rst.out_data", 32'(out_data), 0);
        check("rst.count", 32'(count), 0);
        check("rst.drop_cnt", 32'(drop_cnt), 0);
        reset_n = 1'b1;
        step();

        // Single op with exact capture / release / pop latency
        in_data  = 3'd5;
        in_ready = 1'b1;
        step();  check("lat.e1", 32'(in_read_fin), 0);
        step();  check("lat.e2", 32'(in_read_fin), 0);
        step();  check("lat.e3", 32'(in_read_fin), 1);
        model_push(5);
        check_model("single");
        in_ready = 1'b0;
        step();  check("rel.k1", 32'(in_read_fin), 1);
        step();  check("rel.k2", 32'(in_read_fin), 1);
        step();  check("rel.k3", 32'(in_read_fin), 0);
        out_read_fin = 1'b1;
        step();
        void'(model.pop_front());
        check_model("single.pop");
        out_read_fin = 1'b0;
        step();

        // Order and pointer wrap
        for (int i = 0; i < 12; i++) begin
            push_op(i % 8);
            if (i >= 3) pop_op();
        end
        while (model.size() != 0) pop_op();

`ifdef KBD_QUEUE_OVERWRITE_EN
        for (int i = 0; i < 10; i++) push_op(i);
        check("ovw.count", 32'(count), 8);
        check("ovw.head", 32'(out_data), 2);
        check("ovw.drop", 32'(drop_cnt), 2);
`else
        for (int i = 0; i < DEPTH; i++) push_op(7 - i);
        check("full.count", 32'(count), DEPTH);
        in_data  = 3'd6;
        in_ready = 1'b1;
        step(6);
        check("full.no_ack", 32'(in_read_fin), 0);
        out_read_fin = 1'b1;
        step();
        void'(model.pop_front());
        check("full.pop_no_ack", 32'(in_read_fin), 0);
        check("full.pop_count", 32'(count), DEPTH - 1);
        out_read_fin = 1'b0;
        step();
        check("full.late_ack", 32'(in_read_fin), 1);
        model_push(6);
        check_model("full.refill");
        in_ready = 1'b0;
        wait_fin(1'b0, "full.release");
        check("full.tail", 32'(model[DEPTH-1]), 6);
`endif
        while (model.size() != 0) pop_op();

        // Flush in the same cycle as a capture and a pop
        push_op(1);
        push_op(2);
        in_data  = 3'd3;
        in_ready = 1'b1;
        step(2);
        out_read_fin = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_read_fin = 1'b0;
        model.delete();
        check("flush.fin", 32'(in_read_fin), 1);
        check_model("flush");
        in_ready = 1'b0;
        wait_fin(1'b0, "flush.release");
        check_model("flush.after");

        // Held out_read_fin pops once
        push_op(4);
        push_op(5);
        push_op(6);
        out_read_fin = 1'b1;
        step(5);
        void'(model.pop_front());
        check_model("held");
        out_read_fin = 1'b0;
        step();

        // Reset during ACK, then recapture of the still-high in_ready
        in_data  = 3'd6;
        in_ready = 1'b1;
        wait_fin(1'b1, "rstack.ack");
        #2 reset_n = 1'b0;
        #1;
        check("rstack.fin", 32'(in_read_fin), 0);
        check("rstack.count", 32'(count), 0);
        check("rstack.out_ready", 32'(out_ready), 0);
        model.delete();
        drops = 0;
        step();
        reset_n = 1'b1;
        wait_fin(1'b1, "rstack.reack");
        model_push(6);
        check_model("rstack.recap");
        in_ready = 1'b0;
        wait_fin(1'b0, "rstack.release");

        // Randomized mix, including pops while empty
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 2))
                0: begin
`ifdef KBD_QUEUE_OVERWRITE_EN
                    push_op(int'($urandom_range(0, 7)));
`else
                    if (model.size() < DEPTH) push_op(int'($urandom_range(0, 7)));
`endif
                end
                1: pop_op();
                default: begin
                    step(int'($urandom_range(1, 3)));
                    check_model("idle");
                end
            endcase
        end
        while (model.size() != 0) pop_op();
        pop_op();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
